// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time, holds the returned
// instruction for decode, follows redirects and stops for good after an ECALL.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  part_of_inst,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // an instruction transfers on a cycle where inst_valid && inst_ready. Valid never
  // depends on ready, and the offered payload stays stable until it transfers.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  localparam logic [6:0] ECALL_OPCODE = 7'b1110011;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt, count_nxt;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      inst        <= 32'h0;
      inst_pc     <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      discard     <= discard_nxt;
      inst        <= inst_nxt;
      inst_pc     <= inst_pc_nxt;
      fetch_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    count_nxt   = fetch_count;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_target;
          // A request accepted alongside a redirect is for the stale address.
          if (imem_req_ready) begin
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_target;
          if (imem_resp_valid) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            inst_nxt    = imem_resp_data;
            inst_pc_nxt = pc;
            state_nxt   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          count_nxt = fetch_count + 32'd1;
          pc_nxt    = inst_pc + 32'd4;
          state_nxt = (inst[6:0] == ECALL_OPCODE) ? S_HALT : S_REQ;
        end
      end
      default: begin
        state_nxt = S_HALT;
      end
    endcase
  end

  // The request is masked while reset is held, since the state already reads REQ.
  assign imem_req_valid = (state == S_REQ) && !reset;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign part_of_inst   = inst[6:0];
  assign halted         = (state == S_HALT);

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_addr  output  32  fetch address, word aligned.
REQ-006 imem_req_ready  input  1  memory accepts the request.
REQ-007 imem_resp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_resp_data  input  32  returned instruction word.
REQ-009 inst_valid  output  1  instruction offered to the decode/control stage.
REQ-010 inst  output  32  offered instruction.
REQ-011 inst_pc  output  32  address of the offered instruction.
REQ-012 part_of_inst  output  7  equals inst[6:0], the opcode consumed by the control unit.
REQ-013 inst_ready  input  1  decode stage accepts the offered instruction.
REQ-014 redirect_valid  input  1  control-flow redirect (taken branch, JAL, JALR).
REQ-015 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-016 halted  output  1  an ECALL has been delivered and fetching has stopped.
REQ-017 fetch_count  output  32  number of instructions accepted by decode since reset.

Function
REQ-018 States SHALL be REQ, WAIT, HOLD, HALT; state is observable only through outputs.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-020 WAIT: imem_req_valid=0; at most one request outstanding; on imem_resp_valid, latch data and pc into inst/inst_pc -> HOLD.
REQ-021 HOLD: inst_valid=1; inst, inst_pc, part_of_inst stable until accepted; on inst_valid&&inst_ready, fetch_count+1, pc<=inst_pc+4, -> REQ (same cycle not allowed to re-request; one-cycle bubble).
REQ-022 An accepted instruction with inst[6:0]==7'b1110011 (ECALL) and no simultaneous redirect SHALL go to HALT; halted=1, no further requests; only reset exits HALT.
REQ-023 inst_valid SHALL be 0 in REQ, WAIT and HALT.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count SHALL wrap likewise.
REQ-025 Redirect in REQ without handshake: pc<={redirect_pc[31:2],2'b00}, stay REQ; new address driven next cycle.
REQ-026 Redirect in REQ coinciding with imem_req_ready: request counts as issued; -> WAIT with discard flag set; pc<=redirect target.
REQ-027 Redirect in WAIT: set discard flag, pc<=redirect target; the pending response (including one arriving the same cycle) SHALL be dropped, then -> REQ.
REQ-028 Redirect in HOLD: held instruction dropped (not counted even if inst_ready=1 that cycle, no halt), pc<=redirect target, -> REQ.
REQ-029 Redirect in HALT SHALL be ignored.
REQ-030 imem_resp_valid outside WAIT SHALL be ignored.
REQ-031 Discard flag SHALL clear when the dropped response arrives; a discarded response SHALL never raise inst_valid.

Reset
REQ-032 On reset assertion, asynchronously: state=REQ, pc=RESET_PC, discard=0, inst=32'h0, inst_pc=32'h0, fetch_count=0, halted=0, inst_valid=0.
REQ-033 During reset imem_req_valid SHALL be 0; first request (addr RESET_PC) in the first cycle after deassertion.
REQ-034 Reset mid-transaction SHALL abandon any outstanding request; a late response after reset SHALL be ignored unless it arrives in WAIT of a new request.

Verification
REQ-035 Reset release, ready=1, response 1 cycle later 32'h00500093 -> inst_valid with inst_pc=0, part_of_inst=7'h13; inst_ready=1 -> fetch_count=1, next request addr 32'h4.
REQ-036 HOLD with inst_ready=0 for 5 cycles -> inst/inst_pc unchanged, no new request, fetch_count unchanged.
REQ-037 Redirect to 32'h103 in WAIT, response 32'h00000013 next cycle -> response dropped, next request addr 32'h100, fetch_count unchanged.
REQ-038 Deliver 32'h00000073 at pc 32'h8 and accept -> halted=1, imem_req_valid stays 0 for 20 cycles, redirects ignored.
REQ-039 Deliver ECALL with redirect_valid=1 to 32'h40 the same cycle -> halted=0, not counted, next request addr 32'h40.
REQ-040 RESET_PC=32'hFFFF_FFFC, one instruction accepted -> next request addr 32'h0; reset asserted in WAIT -> all outputs at REQ-032 values immediately.
